// File: rtl/clk_gen_bank_pkg.sv
// clk_gen_bank_pkg: shared constants and types for the clock-enable generator bank.
//   DEF_NUM_CH / DEF_DIV_W / DEF_LOCK_CYCLES : default parameter values
//   lock_state_e                              : lock FSM state encoding
//   sel_w()                                   : channel-select width (at least 1 bit)
package clk_gen_bank_pkg;

  localparam int unsigned DEF_NUM_CH      = 4;
  localparam int unsigned DEF_DIV_W       = 16;
  localparam int unsigned DEF_LOCK_CYCLES = 256;

  typedef enum logic {
    SETTLING = 1'b0,
    LOCKED   = 1'b1
  } lock_state_e;

  // Width of a channel index; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned sel_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clk_gen_bank_if.sv
// clk_gen_bank_if: configuration handshake, channel enables and divided outputs.
//   master : drives ch_en, cfg_valid, cfg_ch, cfg_div, cfg_phase;
//            observes cfg_ready, clk_en, clk_sq, lock
//   slave  : the generator bank (mirror directions)
interface clk_gen_bank_if #(
  parameter int unsigned NUM_CH = clk_gen_bank_pkg::DEF_NUM_CH,
  parameter int unsigned DIV_W  = clk_gen_bank_pkg::DEF_DIV_W
);
  localparam int unsigned CH_W = clk_gen_bank_pkg::sel_w(NUM_CH);

  logic [NUM_CH-1:0] ch_en;
  logic              cfg_valid;
  logic [CH_W-1:0]   cfg_ch;
  logic [DIV_W-1:0]  cfg_div;
  logic [DIV_W-1:0]  cfg_phase;
  logic              cfg_ready;
  logic [NUM_CH-1:0] clk_en;
  logic [NUM_CH-1:0] clk_sq;
  logic              lock;

  modport master (
    output ch_en, cfg_valid, cfg_ch, cfg_div, cfg_phase,
    input  cfg_ready, clk_en, clk_sq, lock
  );

  modport slave (
    input  ch_en, cfg_valid, cfg_ch, cfg_div, cfg_phase,
    output cfg_ready, clk_en, clk_sq, lock
  );

endinterface

// File: rtl/clk_gen_ch.sv
// clk_gen_ch: one divided-clock channel with a pending-update register that is
// retimed onto the channel's terminal count.
//   clk, rst            : system clock, async active-high reset
//   ch_en               : channel run enable
//   cfg_we              : accepted configuration for this channel (only when !pend)
//   cfg_div, cfg_phase  : new divisor and counter load value
//   sync                : (CLK_GEN_BANK_SYNC_EN only) reload phase, suppress strobe
//   pend                : update waiting to be applied (registered)
//   apply_c             : pending update is applied at the coming edge
//   clk_en, clk_sq      : registered strobe and square wave
module clk_gen_ch #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ch_en,
  input  logic             cfg_we,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [DIV_W-1:0] cfg_phase,
`ifdef CLK_GEN_BANK_SYNC_EN
  input  logic             sync,
`endif
  output logic             pend,
  output logic             apply_c,
  output logic             clk_en,
  output logic             clk_sq
);

  logic [DIV_W-1:0] div_q, phase_q, cnt_q, pdiv_q, pphase_q;
  logic             pend_q, run_q, en_q, sq_q;

  logic [DIV_W-1:0] div_n, phase_n, eff_n, cnt_n, pdiv_n, pphase_n;
  logic             pend_n, run_n, en_n, sq_n;
  logic             active, tc, load, resync;

  // Next-state: apply pending update, capture new request, advance the counter.
  // Outputs are derived from the next count so they line up with the count register.
  always_comb begin
    div_n    = div_q;
    phase_n  = phase_q;
    pdiv_n   = pdiv_q;
    pphase_n = pphase_q;
    pend_n   = pend_q;
    load     = 1'b0;
    cnt_n    = cnt_q;
    run_n    = run_q;
    en_n     = 1'b0;
    sq_n     = 1'b0;
`ifdef CLK_GEN_BANK_SYNC_EN
    resync   = sync;
`else
    resync   = 1'b0;
`endif

    active = ch_en && (div_q != '0);
    tc     = active && run_q && (cnt_q == div_q - DIV_W'(1));

    // A stopped channel takes the update at once; a running one waits for its
    // terminal count so the period in flight always completes.
    if (pend_q && (!active || tc)) begin
      div_n   = pdiv_q;
      phase_n = pphase_q;
      pend_n  = 1'b0;
      load    = 1'b1;
    end

    // cfg_we is only raised while pend_q is low, so it never races the apply above.
    if (cfg_we) begin
      pend_n   = 1'b1;
      pdiv_n   = cfg_div;
      pphase_n = cfg_phase;
    end

    eff_n = (phase_n < div_n) ? phase_n : '0;

    if (div_n == '0) begin
      cnt_n = '0;
      run_n = 1'b0;
    end else if (!ch_en) begin
      cnt_n = eff_n;
      run_n = 1'b0;
    end else begin
      run_n = 1'b1;
      // First running cycle after enable, an applied update, or a sync reloads phase.
      if (load || !run_q || resync) begin
        cnt_n = eff_n;
      end else if (cnt_q == div_q - DIV_W'(1)) begin
        cnt_n = '0;
      end else begin
        cnt_n = cnt_q + DIV_W'(1);
      end
      en_n = (cnt_n == div_n - DIV_W'(1));
      sq_n = (cnt_n < (div_n >> 1));
      // Retiming load never adds a strobe, except div==1 which strobes every cycle.
      if (load && (div_n != DIV_W'(1))) en_n = 1'b0;
      if (resync) en_n = 1'b0;
    end

    apply_c = load;
  end

  // Channel state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q    <= '0;
      phase_q  <= '0;
      cnt_q    <= '0;
      pdiv_q   <= '0;
      pphase_q <= '0;
      pend_q   <= 1'b0;
      run_q    <= 1'b0;
      en_q     <= 1'b0;
      sq_q     <= 1'b0;
    end else begin
      div_q    <= div_n;
      phase_q  <= phase_n;
      cnt_q    <= cnt_n;
      pdiv_q   <= pdiv_n;
      pphase_q <= pphase_n;
      pend_q   <= pend_n;
      run_q    <= run_n;
      en_q     <= en_n;
      sq_q     <= sq_n;
    end
  end

  assign pend   = pend_q;
  assign clk_en = en_q;
  assign clk_sq = sq_q;

endmodule

// File: rtl/clk_gen_bank.sv
// clk_gen_bank: bank of NUM_CH programmable clock-enable generators with a
// shared configuration port and a lock indicator.
//   clk, rst : system clock, async active-high reset
//   sync     : present only with `define CLK_GEN_BANK_SYNC_EN; realigns all
//              enabled channels to their phase
//   bus      : clk_gen_bank_if.slave (ch_en, cfg_* handshake, clk_en, clk_sq, lock)
module clk_gen_bank import clk_gen_bank_pkg::*; #(
  parameter int unsigned NUM_CH      = DEF_NUM_CH,
  parameter int unsigned DIV_W       = DEF_DIV_W,
  parameter int unsigned LOCK_CYCLES = DEF_LOCK_CYCLES
) (
  input  logic          clk,
  input  logic          rst,
`ifdef CLK_GEN_BANK_SYNC_EN
  input  logic          sync,
`endif
  clk_gen_bank_if.slave bus
);

  localparam int unsigned CH_W = sel_w(NUM_CH);
  localparam int unsigned CH_N = 1 << CH_W;
  localparam int unsigned LC_W = $clog2(LOCK_CYCLES + 1);

  logic [NUM_CH-1:0] pend, apply_c;
  logic [CH_N-1:0]   pend_pad, sel_pad;
  logic              ready_c, acc_c, apply_any, pend_any;

  lock_state_e       state;
  logic [LC_W-1:0]   settle;
  logic              lock_q;

  // Config decode: padding to a power of two makes unused channel codes read as
  // ready and accept into nothing.
  always_comb begin
    pend_pad = CH_N'(pend);
    ready_c  = ~pend_pad[bus.cfg_ch];
    acc_c    = bus.cfg_valid & ready_c;
    sel_pad  = CH_N'(acc_c) << bus.cfg_ch;
  end

  assign bus.cfg_ready = ready_c;
  assign apply_any     = |apply_c;
  assign pend_any      = |pend;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_gen_ch #(
      .DIV_W(DIV_W)
    ) u_ch (
      .clk      (clk),
      .rst      (rst),
      .ch_en    (bus.ch_en[i]),
      .cfg_we   (sel_pad[i]),
      .cfg_div  (bus.cfg_div),
      .cfg_phase(bus.cfg_phase),
`ifdef CLK_GEN_BANK_SYNC_EN
      .sync     (sync),
`endif
      .pend     (pend[i]),
      .apply_c  (apply_c[i]),
      .clk_en   (bus.clk_en[i]),
      .clk_sq   (bus.clk_sq[i])
    );
  end

  // Lock FSM: LOCK_CYCLES consecutive quiet cycles in SETTLING earn LOCKED;
  // any acceptance or applied update restarts settling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= SETTLING;
      settle <= '0;
      lock_q <= 1'b0;
    end else begin
      case (state)
        SETTLING: begin
          if (acc_c || apply_any || pend_any) begin
            settle <= '0;
          end else if (settle == LC_W'(LOCK_CYCLES - 1)) begin
            state  <= LOCKED;
            settle <= '0;
            lock_q <= 1'b1;
          end else begin
            settle <= settle + LC_W'(1);
          end
        end
        LOCKED: begin
          if (acc_c || apply_any) begin
            state  <= SETTLING;
            settle <= '0;
            lock_q <= 1'b0;
          end
        end
        default: begin
          state  <= SETTLING;
          settle <= '0;
          lock_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.lock = lock_q;

endmodule

// File: doc/clk_gen_bank.md
CLK_GEN_BANK -- requirements
Module: clk_gen_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of output channels (1..8).
REQ-002 SHALL have parameter DIV_W, default 16, divisor/phase width in bits.
REQ-003 SHALL have parameter LOCK_CYCLES, default 256, settle cycles before lock reasserts.
REQ-004 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-006 SHALL have port ch_en  input  NUM_CH  per-channel run enable.
REQ-007 SHALL have port cfg_valid  input  1  configuration request.
REQ-008 SHALL have port cfg_ch  input  clog2(NUM_CH)  target channel.
REQ-009 SHALL have port cfg_div  input  DIV_W  new divisor.
REQ-010 SHALL have port cfg_phase  input  DIV_W  counter load value after update or enable.
REQ-011 SHALL have port cfg_ready  output  1  request accepted when cfg_valid and cfg_ready are both high.
REQ-012 SHALL have port clk_en  output  NUM_CH  one-cycle strobe per divided period.
REQ-013 SHALL have port clk_sq  output  NUM_CH  registered divided square wave.
REQ-014 SHALL have port lock  output  1  all channels stable.

Function
REQ-015 Each channel SHALL have a counter running 0..div-1; clk_en[i] high on the cycle where count==div-1.
REQ-016 clk_sq[i] SHALL be high while count < div/2 (integer division), so odd div gives a shorter high phase.
REQ-017 div==0 SHALL disable the channel: count held at 0, clk_en and clk_sq low.
REQ-018 div==1 SHALL drive clk_en high every cycle and hold clk_sq low.
REQ-019 ch_en[i] low SHALL hold count at the effective phase and force outputs low; counting SHALL resume from phase on the first cycle ch_en is high.
REQ-020 Effective phase SHALL be cfg_phase when cfg_phase < div, else 0.
REQ-021 Accepted request SHALL be stored as pending for cfg_ch; cfg_ready SHALL equal NOT pending[cfg_ch] (combinational on cfg_ch).
REQ-022 Pending update SHALL apply on the channel's next terminal count (count==div-1) from the following cycle onward, giving glitch-free retiming; count loads the effective phase, no extra strobe.
REQ-023 Update SHALL apply on the next cycle if the channel is disabled (div==0 or ch_en low).
REQ-024 Acceptance coinciding with terminal count SHALL NOT apply in that cycle; it waits for the next terminal count.
REQ-025 Lock FSM SHALL have states SETTLING and LOCKED; any acceptance or any applied update forces SETTLING and clears the settle counter.
REQ-026 SETTLING SHALL move to LOCKED after LOCK_CYCLES consecutive cycles with no pending update; lock high only in LOCKED.
REQ-027 Output and clk_sq latency from count change SHALL be zero extra cycles (outputs registered with count).

Reset
REQ-028 rst high SHALL asynchronously clear: all div and phase to 0, counts 0, pending 0, clk_en 0, clk_sq 0, lock 0, FSM to SETTLING with settle counter 0.
REQ-029 Reset mid-update SHALL discard pending updates; lock SHALL reassert LOCK_CYCLES cycles after rst falls.

Configuration
REQ-030 Macro CLK_GEN_BANK_SYNC_EN SHALL add input port sync (1 bit); sync high SHALL load every enabled channel's count with its effective phase next cycle, suppress clk_en that cycle, and not affect lock.
REQ-031 Without CLK_GEN_BANK_SYNC_EN the sync port and logic SHALL be absent; behaviour otherwise identical.

Structure
REQ-032 Package clk_gen_bank_pkg SHALL hold default parameter constants and the lock-state enum.
REQ-033 Per-channel counter, pending register and retiming SHALL be sub-module clk_gen_ch, instantiated NUM_CH times; lock FSM and cfg decode in the top.

Verification
REQ-034 Reset release, ch0 div=4 phase=0, ch_en=1 -> clk_en[0] every 4th cycle, clk_sq[0] 2 high/2 low; lock high 256 cycles after last update.
REQ-035 ch1 div=5 then reprogram div=3 mid-period -> 5-cycle period completes, then 3-cycle periods; no short strobe; lock drops and returns.
REQ-036 Second cfg to ch1 while pending -> cfg_ready low for ch1, high for cfg_ch=2; request to ch2 accepted same cycle.
REQ-037 div=1 -> clk_en constant 1, clk_sq 0; div=0 -> both 0; phase=7 with div=4 -> loads 0.
REQ-038 ch_en toggle off/on with phase=2, div=4 -> first strobe 2 cycles after re-enable.
REQ-039 With CLK_GEN_BANK_SYNC_EN: ch0 div=4, ch1 div=8, pulse sync -> both counts at phase next cycle, clk_en aligned every 8th cycle; rst mid-pending -> pending cleared, outputs 0.
